raw10_unpacker: RTL

Downstream stage of `data_aligner` in the CSI-2 receive path. Consumes byte-aligned payload words and unpacks MIPI RAW10 (5 bytes → 4 pixels) through an internal 4-to-5 byte gearbox. Emits one group of four 10-bit pixels per cycle, with line-end marking and a per-line pixel count. There is no backpressure; the pixel sink must accept every `pixel_valid` beat.

---
 rtl/raw10_unpacker.sv | 94 +++++++++
 1 files changed

// File: rtl/raw10_unpacker.sv
// raw10_unpacker
// Unpacks MIPI RAW10 (5 bytes -> 4 x 10-bit pixels) from 32-bit byte-aligned
// payload words through an 8-byte gearbox. No backpressure.
//
// Ports:
//   clk, rst       sole clock; asynchronous active-high reset
//   aligned_data   payload word, byte 0 = [7:0] is first on the wire
//   data_valid     aligned_data valid this cycle
//   end_of_packet  last payload beat of a line (qualified by data_valid)
//   pixel_data     P0=[9:0] .. P3=[39:30], held between pulses
//   pixel_valid    one-cycle pulse per group
//   line_end       one-cycle pulse closing a line
//   line_pixels    pixel count of the last completed line
//   fmt_error      sticky: a line length was not a multiple of 5 bytes
module raw10_unpacker #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] aligned_data,
  input  logic                  data_valid,
  input  logic                  end_of_packet,
  output logic [39:0]           pixel_data,
  output logic                  pixel_valid,
  output logic                  line_end,
  output logic [15:0]           line_pixels,
  output logic                  fmt_error
);

  // Bytes above cnt_q are always kept zero, so appending is a plain OR.
  logic [63:0] byte_buf;
  logic [3:0]  cnt_q;
  logic [15:0] pix_cnt;

  logic [63:0] merged;
  logic [63:0] shifted;
  logic [3:0]  cnt_sum;
  logic [3:0]  cnt_rem;
  logic        emit;
  logic        eop_beat;
  logic [39:0] unpacked;
  logic [15:0] pix_next;

  always_comb begin
    merged   = byte_buf | (64'(aligned_data) << {cnt_q, 3'b000});
    cnt_sum  = cnt_q + 4'd4;
    emit     = data_valid && (cnt_sum >= 4'd5);
    eop_beat = data_valid && end_of_packet;
    shifted  = merged >> 40;
    cnt_rem  = emit ? (cnt_sum - 4'd5) : cnt_sum;
    unpacked = '0;
    for (int unsigned n = 0; n < 4; n++) begin
      unpacked[n*10 +: 10] = {merged[n*8 +: 8], merged[32 + 2*n +: 2]};
    end
    pix_next = pix_cnt;
    if (emit) begin
      pix_next = (pix_cnt > 16'd65531) ? 16'hFFFF : pix_cnt + 16'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_buf    <= '0;
      cnt_q       <= '0;
      pix_cnt     <= '0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      line_end    <= 1'b0;
      line_pixels <= '0;
      fmt_error   <= 1'b0;
    end else begin
      pixel_valid <= emit;
      line_end    <= eop_beat;
      if (emit) begin
        pixel_data <= unpacked;
      end
      if (eop_beat) begin
        // Line closes: any residual bytes are dropped and flagged.
        byte_buf    <= '0;
        cnt_q       <= '0;
        pix_cnt     <= '0;
        line_pixels <= pix_next;
        if (cnt_rem != 4'd0) begin
          fmt_error <= 1'b1;
        end
      end else if (data_valid) begin
        byte_buf <= emit ? shifted : merged;
        cnt_q    <= cnt_rem;
        pix_cnt  <= pix_next;
      end
    end
  end

endmodule
